// File: rtl/vga_sprite_defs_pkg.sv
// Shared VGA sprite constants: raster widths, sheet geometry, animation rate.
// Also holds the ping-pong direction type used by the animation sequencer.
package vga_sprite_defs;

    localparam int CNT_BITS_N      = 10;
    localparam int PX_ADDR_BITS_N  = 17;
    localparam int SPR_W           = 34;
    localparam int SPR_H           = 24;
    localparam int FRAMES_N        = 3;
    localparam int SCALE_SHIFT     = 1;
    localparam int TICKS_PER_FRAME = 6;
    localparam int FRAME_BITS      = 2;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

endpackage

// File: rtl/sprite_anim_seq.sv
// Animation sequencer: tick divider, frame index, ping-pong direction,
// pending forced frame and mirror latch, all updated only on frame_start.
module sprite_anim_seq
    import vga_sprite_defs::*;
#(
    parameter int FRAMES = 3,
    parameter int TICKS  = 6,
    parameter int FBITS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             anim_en,
    input  logic             anim_mode,
    input  logic             mirror_h,
    input  logic             frame_sel_load,
    input  logic [FBITS-1:0] frame_sel,
    output logic [FBITS-1:0] cur_frame,
    output logic             mirror_q
);

    localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [FBITS-1:0] LAST = FBITS'(FRAMES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

    logic [FBITS-1:0] frame_q, frame_n;
    logic [TW-1:0]    tick_q, tick_n;
    dir_t             dir_q, dir_n;
    logic             pend_vld_q, pend_vld_n;
    logic [FBITS-1:0] pend_q, pend_n;
    logic             mirror_n;
    logic [FBITS-1:0] load_val;
    logic [FBITS-1:0] step_frame;
    dir_t             step_dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q    <= '0;
            tick_q     <= '0;
            dir_q      <= DIR_UP;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            mirror_q   <= 1'b0;
        end else begin
            frame_q    <= frame_n;
            tick_q     <= tick_n;
            dir_q      <= dir_n;
            pend_vld_q <= pend_vld_n;
            pend_q     <= pend_n;
            mirror_q   <= mirror_n;
        end
    end

    always_comb begin
        step_frame = frame_q;
        step_dir   = dir_q;
        if (FRAMES == 1) begin
            step_frame = '0;
        end else if (!anim_mode) begin
            step_frame = (frame_q == LAST) ? '0
                       : frame_q + FBITS'(1);
        end else begin
            unique case (dir_q)
                DIR_UP: begin
                    if (frame_q == LAST) begin
                        step_frame = frame_q - FBITS'(1);
                        step_dir   = DIR_DOWN;
                    end else begin
                        step_frame = frame_q + FBITS'(1);
                    end
                end
                DIR_DOWN: begin
                    if (frame_q == '0) begin
                        step_frame = frame_q + FBITS'(1);
                        step_dir   = DIR_UP;
                    end else begin
                        step_frame = frame_q - FBITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        frame_n    = frame_q;
        tick_n     = tick_q;
        dir_n      = dir_q;
        pend_vld_n = pend_vld_q;
        pend_n     = pend_q;
        mirror_n   = mirror_q;
        load_val   = (frame_sel > LAST) ? LAST : frame_sel;
        if (frame_sel_load) begin
            pend_vld_n = 1'b1;
            pend_n     = load_val;
        end
        // A load arriving on the frame_start cycle itself applies at once.
        if (frame_start) begin
            mirror_n = mirror_h;
            if (frame_sel_load || pend_vld_q) begin
                frame_n    = frame_sel_load ? load_val : pend_q;
                tick_n     = '0;
                pend_vld_n = 1'b0;
                pend_n     = '0;
            end else if (anim_en) begin
                if (tick_q == TICK_LAST) begin
                    tick_n  = '0;
                    frame_n = step_frame;
                    dir_n   = step_dir;
                end else begin
                    tick_n = tick_q + TW'(1);
                end
            end
        end
    end

    assign cur_frame = frame_q;

endmodule

// File: rtl/sprite_anim_addr_gen.sv
// Sprite-sheet address generator: raster hit test, sheet address
// arithmetic and registered ROM address/valid for one animated sprite.
module sprite_anim_addr_gen #(
    parameter int CNT_BITS_N      = vga_sprite_defs::CNT_BITS_N,
    parameter int PX_ADDR_BITS_N  = vga_sprite_defs::PX_ADDR_BITS_N,
    parameter int SPR_W           = vga_sprite_defs::SPR_W,
    parameter int SPR_H           = vga_sprite_defs::SPR_H,
    parameter int FRAMES_N        = vga_sprite_defs::FRAMES_N,
    parameter int SCALE_SHIFT     = vga_sprite_defs::SCALE_SHIFT,
    parameter int TICKS_PER_FRAME = vga_sprite_defs::TICKS_PER_FRAME,
    parameter int FRAME_BITS      = vga_sprite_defs::FRAME_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CNT_BITS_N-1:0]     h_cnt,
    input  logic [CNT_BITS_N-1:0]     v_cnt,
    input  logic [CNT_BITS_N-1:0]     pos_h_cnt,
    input  logic [CNT_BITS_N-1:0]     pos_v_cnt,
    input  logic                      frame_start,
    input  logic                      anim_en,
    input  logic                      anim_mode,
    input  logic                      mirror_h,
    input  logic                      frame_sel_load,
    input  logic [FRAME_BITS-1:0]     frame_sel,
    output logic [PX_ADDR_BITS_N-1:0] pixel_addr,
    output logic                      valid,
    output logic [FRAME_BITS-1:0]     cur_frame
);

    localparam int CW = CNT_BITS_N + 1;
    localparam int AW = PX_ADDR_BITS_N;

    logic                  mirror_q;
    logic [CNT_BITS_N-1:0] x, y, dx, dy, col;
    logic [CW-1:0]         x_e, y_e, ph_e, pv_e;
    logic                  hit;
    logic [AW-1:0]         addr_c;

    sprite_anim_seq #(
        .FRAMES (FRAMES_N),
        .TICKS  (TICKS_PER_FRAME),
        .FBITS  (FRAME_BITS)
    ) u_seq (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .anim_en        (anim_en),
        .anim_mode      (anim_mode),
        .mirror_h       (mirror_h),
        .frame_sel_load (frame_sel_load),
        .frame_sel      (frame_sel),
        .cur_frame      (cur_frame),
        .mirror_q       (mirror_q)
    );

    assign x    = h_cnt >> SCALE_SHIFT;
    assign y    = v_cnt >> SCALE_SHIFT;
    assign x_e  = {1'b0, x};
    assign y_e  = {1'b0, y};
    assign ph_e = {1'b0, pos_h_cnt};
    assign pv_e = {1'b0, pos_v_cnt};

    // Extra bit keeps pos + size from wrapping near the raster edge.
    assign hit = (x_e >= ph_e) && (x_e < ph_e + CW'(SPR_W))
              && (y_e >= pv_e) && (y_e < pv_e + CW'(SPR_H));

    assign dx  = x - pos_h_cnt;
    assign dy  = y - pos_v_cnt;
    assign col = mirror_q ? CNT_BITS_N'(SPR_W - 1) - dx : dx;

    assign addr_c = AW'(cur_frame) * AW'(SPR_W)
                  + AW'(col)
                  + AW'(dy) * AW'(SPR_W * FRAMES_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr <= '0;
            valid      <= 1'b0;
        end else begin
            pixel_addr <= hit ? addr_c : '0;
            valid      <= hit;
        end
    end

endmodule

// File: tb/tb_sprite_anim_addr_gen.sv
// Bench for sprite_anim_addr_gen: directed steps plus randomized
// pixel/animation traffic against an arithmetic reference model.
module tb_sprite_anim_addr_gen;

    localparam int CB  = 10;
    localparam int AB  = 17;
    localparam int SW  = 34;
    localparam int SH  = 24;
    localparam int NF  = 3;
    localparam int SS  = 1;
    localparam int TPF = 6;
    localparam int FB  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CB-1:0] h_cnt, v_cnt, pos_h_cnt, pos_v_cnt;
    logic          frame_start, anim_en, anim_mode, mirror_h;
    logic          frame_sel_load;
    logic [FB-1:0] frame_sel;
    logic [AB-1:0] pixel_addr;
    logic          valid;
    logic [FB-1:0] cur_frame;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_tick, m_phase, m_mode, m_mirror;
    int ph, pv;

    always #5 clk = ~clk;

    sprite_anim_addr_gen dut (
        .clk            (clk),
        .rst            (rst),
        .h_cnt          (h_cnt),
        .v_cnt          (v_cnt),
        .pos_h_cnt      (pos_h_cnt),
        .pos_v_cnt      (pos_v_cnt),
        .frame_start    (frame_start),
        .anim_en        (anim_en),
        .anim_mode      (anim_mode),
        .mirror_h       (mirror_h),
        .frame_sel_load (frame_sel_load),
        .frame_sel      (frame_sel),
        .pixel_addr     (pixel_addr),
        .valid          (valid),
        .cur_frame      (cur_frame)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            cyc();
            frame_start = 1'b0;
        end
    endtask

    task automatic pix(input int h, input int v);
        h_cnt = CB'(h);
        v_cnt = CB'(v);
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    function automatic int pp_frame(input int k);
        int p;
        p = k % (2 * NF - 2);
        return (p < NF) ? p : 2 * NF - 2 - p;
    endfunction

    function automatic int m_frame();
        if (m_mode == 0) return m_phase;
        return pp_frame(m_phase);
    endfunction

    initial begin
        rst = 1'b1;
        h_cnt = '0; v_cnt = '0;
        pos_h_cnt = '0; pos_v_cnt = '0;
        frame_start = 0; anim_en = 0; anim_mode = 0;
        mirror_h = 0; frame_sel_load = 0; frame_sel = '0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_addr", 32'(pixel_addr), 0);
        chk("rst_frame", 32'(cur_frame), 0);

        // hit / miss boundaries
        pos_h_cnt = 10'd100;
        pos_v_cnt = 10'd50;
        pix(200, 100);
        chk("hit_valid", 32'(valid), 1);
        chk("hit_addr", 32'(pixel_addr), 0);
        pix(267, 100);
        chk("right_edge_addr", 32'(pixel_addr), 33);
        pix(268, 100);
        chk("right_miss_valid", 32'(valid), 0);
        chk("right_miss_addr", 32'(pixel_addr), 0);
        pix(200, 147);
        chk("bottom_row_addr", 32'(pixel_addr), 23 * 102);
        pix(200, 148);
        chk("bottom_miss_valid", 32'(valid), 0);
        pix(199, 100);
        chk("left_miss_valid", 32'(valid), 0);

        // loop animation
        anim_en = 1; anim_mode = 0;
        pulse(5);
        chk("loop_5", 32'(cur_frame), 0);
        pulse(1);
        chk("loop_6", 32'(cur_frame), 1);
        pix(200, 100);
        chk("loop_f1_addr", 32'(pixel_addr), 34);
        pulse(12);
        chk("loop_18", 32'(cur_frame), 0);
        pulse(3);
        anim_en = 0;
        pulse(10);
        chk("hold_frame", 32'(cur_frame), 0);
        anim_en = 1;
        pulse(2);
        chk("hold_tick_a", 32'(cur_frame), 0);
        pulse(1);
        chk("hold_tick_b", 32'(cur_frame), 1);

        // ping-pong from a clean start
        do_reset();
        anim_mode = 1;
        chk("pp_0", 32'(cur_frame), 0);
        for (int k = 1; k <= 6; k++) begin
            pulse(6);
            chk($sformatf("pp_%0d", k), 32'(cur_frame),
                32'(pp_frame(k)));
        end

        // mirror, frame-synchronous
        anim_en = 0; anim_mode = 0;
        mirror_h = 1;
        frame_sel = 2'd2; frame_sel_load = 1;
        cyc();
        frame_sel_load = 0;
        pulse(1);
        chk("mir_frame", 32'(cur_frame), 2);
        pix(200, 102);
        chk("mir_addr", 32'(pixel_addr), 203);
        mirror_h = 0;
        pix(200, 102);
        chk("mir_hold", 32'(pixel_addr), 203);
        pulse(1);
        pix(200, 102);
        chk("mir_off", 32'(pixel_addr), 170);

        // load coincident with an advance
        anim_en = 1;
        frame_sel = 2'd0; frame_sel_load = 1;
        pulse(1);
        frame_sel_load = 0;
        chk("load0", 32'(cur_frame), 0);
        pulse(5);
        chk("pre_adv", 32'(cur_frame), 0);
        frame_sel = 2'd2; frame_sel_load = 1;
        pulse(1);
        frame_sel_load = 0;
        chk("load_wins", 32'(cur_frame), 2);
        pulse(5);
        chk("load_tick0_a", 32'(cur_frame), 2);
        pulse(1);
        chk("load_tick0_b", 32'(cur_frame), 0);

        // mid-frame load, latest wins, clamp
        frame_sel = 2'd1; frame_sel_load = 1;
        cyc();
        frame_sel = 2'd3;
        cyc();
        frame_sel_load = 0;
        cyc();
        chk("pend_hold", 32'(cur_frame), 0);
        pulse(1);
        chk("clamp", 32'(cur_frame), 2);

        // reset mid-run at frame 2, tick 4
        pulse(4);
        pix(200, 100);
        chk("pre_rst_valid", 32'(valid), 1);
        chk("pre_rst_frame", 32'(cur_frame), 2);
        do_reset();
        chk("mrst_frame", 32'(cur_frame), 0);
        chk("mrst_valid", 32'(valid), 0);
        chk("mrst_addr", 32'(pixel_addr), 0);
        pulse(5);
        chk("mrst_tick_a", 32'(cur_frame), 0);
        pulse(1);
        chk("mrst_tick_b", 32'(cur_frame), 1);

        // randomized traffic against the model
        do_reset();
        m_tick = 0; m_phase = 0; m_mirror = 0;
        m_mode = int'($urandom_range(0, 1));
        anim_mode = m_mode[0];
        ph = int'($urandom_range(5, 400));
        pv = int'($urandom_range(5, 400));
        pos_h_cnt = CB'(ph);
        pos_v_cnt = CB'(pv);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                anim_en  = ($urandom_range(0, 9) < 8);
                mirror_h = $urandom_range(0, 1) == 1;
                pulse(1);
                m_mirror = mirror_h;
                if (anim_en) begin
                    if (m_tick == TPF - 1) begin
                        m_tick  = 0;
                        m_phase = (m_phase + 1)
                            % ((m_mode == 1) ? 2 * NF - 2 : NF);
                    end else begin
                        m_tick++;
                    end
                end
                chk("rnd_frame", 32'(cur_frame), 32'(m_frame()));
            end else begin
                int x, y, dx, dy, hit, col, exp;
                x = ph + int'($urandom_range(0, SW + 9)) - 5;
                y = pv + int'($urandom_range(0, SH + 9)) - 5;
                pix(x * 2 + int'($urandom_range(0, 1)),
                    y * 2 + int'($urandom_range(0, 1)));
                dx  = x - ph;
                dy  = y - pv;
                hit = (dx >= 0 && dx < SW && dy >= 0 && dy < SH);
                col = m_mirror ? SW - 1 - dx : dx;
                exp = hit ? m_frame() * SW + col + dy * SW * NF : 0;
                chk("rnd_valid", 32'(valid), 32'(hit));
                chk("rnd_addr", 32'(pixel_addr), 32'(exp));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_anim_addr_gen.md
Name: sprite_anim_addr_gen

Overview:
Generalised sprite-sheet address generator for the VGA pipeline. It maps the current raster position to a ROM pixel address for one animated sprite. Frames are laid side by side in one sheet, and the animation advances at a programmable rate, locked to the video frame. It adds loop and ping-pong modes, horizontal mirroring, frame override and registered outputs, and sits between the VGA timing counters and the sprite block ROM.

Parameters:
CNT_BITS_N, 10, width of raster/position counters
PX_ADDR_BITS_N, 17, width of ROM pixel address
SPR_W, 34, sprite frame width in sheet pixels
SPR_H, 24, sprite frame height in sheet pixels
FRAMES_N, 3, number of frames in sheet (>=1)
SCALE_SHIFT, 1, raster-to-sheet downscale (coord >> SCALE_SHIFT)
TICKS_PER_FRAME, 6, video frames per animation step (>=1)
FRAME_BITS, 2, width of frame index, >= clog2(FRAMES_N)

Ports:
clk  in  1  pixel clock
rst  in  1  reset
h_cnt  in  CNT_BITS_N  raster column
v_cnt  in  CNT_BITS_N  raster row
pos_h_cnt  in  CNT_BITS_N  sprite left edge, scaled coordinates
pos_v_cnt  in  CNT_BITS_N  sprite top edge, scaled coordinates
frame_start  in  1  one-cycle pulse per video frame (start of vblank)
anim_en  in  1  1 = animation advances
anim_mode  in  1  0 = loop, 1 = ping-pong
mirror_h  in  1  1 = horizontally flipped sprite
frame_sel_load  in  1  request to force frame
frame_sel  in  FRAME_BITS  forced frame index
pixel_addr  out  PX_ADDR_BITS_N  ROM address, registered
valid  out  1  raster inside sprite, registered
cur_frame  out  FRAME_BITS  displayed frame index

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset clears pixel_addr to 0, valid to 0, cur_frame to 0, tick counter to 0, direction to up, pending load to 0 and latched mirror to 0. Reset mid-animation takes effect on the next edge.
- Scaled coordinates: x = h_cnt >> SCALE_SHIFT, y = v_cnt >> SCALE_SHIFT.
- Hit condition: pos_h_cnt <= x < pos_h_cnt + SPR_W and pos_v_cnt <= y < pos_v_cnt + SPR_H. Sums are computed at CNT_BITS_N+1 bits, so there is no wrap.
- Address terms:
  - dx = x - pos_h_cnt
  - dy = y - pos_v_cnt
  - col = mirror_q ? SPR_W-1-dx : dx
- Address on hit: addr = cur_frame*SPR_W + col + dy*SPR_W*FRAMES_N. On miss: addr = 0, valid = 0.
- Latency: one clock from h_cnt/v_cnt to pixel_addr/valid.
- Frame-synchronous update: cur_frame, tick and mirror_q change only on a cycle with frame_start = 1, so there is no tearing mid-frame.
- frame_sel_load (any cycle):
  - Latches frame_sel into a pending register, clamped to FRAMES_N-1 if out of range.
  - The latest request wins.
  - At the next frame_start, cur_frame takes the pending value, tick is cleared and pending is cleared.
  - A load takes priority over a simultaneous advance.
- Tick counter: on frame_start with anim_en = 1 (and no pending load):
  - If tick == TICKS_PER_FRAME-1: tick <= 0 and the frame advances.
  - Otherwise tick increments.
  - With anim_en = 0, tick and frame hold.
- Loop mode: frame advances 0 -> 1 -> ... -> FRAMES_N-1 -> 0.
- Ping-pong mode:
  - Going up, the direction reverses at FRAMES_N-1; going down, it reverses at 0. The endpoint is shown once.
  - FRAMES_N = 2 gives 0,1,0,1.
  - Switching mode mid-run keeps the current frame and direction.
- FRAMES_N = 1: cur_frame is held at 0.
- mirror_q samples mirror_h on each frame_start.

Decomposition:
- Shared package/include (vga_sprite_defs): CNT_BITS_N, PX_ADDR_BITS_N and the sprite geometry constants per sprite.
- Natural sub-module: sprite_anim_seq, containing tick counter, frame index, direction and pending load. It outputs cur_frame and mirror_q.
- The top level holds the hit test, the address arithmetic and the output register.

Test Plan:
- Hit/miss: after reset, pos = (100,50) with defaults.
  - h=200, v=100 -> next cycle valid = 1, addr = 0.
  - h=267 -> addr = 33.
  - h=268 -> valid = 0, addr = 0.
  - v=148 -> y = 74, valid = 0.
- Loop animation: anim_en = 1, anim_mode = 0.
  - After 6 frame_start pulses, cur_frame = 1 and pixel (dx=0, dy=0) gives addr = 34.
  - After 18 pulses, cur_frame = 0.
  - With anim_en = 0, 10 pulses -> unchanged.
- Ping-pong: anim_mode = 1, 36 pulses -> cur_frame sequence every 6 pulses is 0,1,2,1,0,1,2.
- Mirror: mirror_h = 1, forced frame 2, then a frame_start. Pixel dx=0, dy=1 -> addr = 68 + 33 + 102 = 203. Toggling mirror_h mid-frame has no effect until the next frame_start.
- Forced frame:
  - frame_sel_load with frame_sel = 2 mid-frame -> cur_frame unchanged until the next frame_start, then 2, tick = 0.
  - frame_sel = 3 -> clamped to 2.
  - A load coincident with an advance pulse -> the loaded value wins.
- Reset mid-run: at frame 2, tick 4, while valid = 1, assert rst for one cycle -> next cycle cur_frame = 0, valid = 0, addr = 0, tick = 0.
